// File: rtl/lsu_initiator.sv
// lsu_initiator: load/store initiator between the pipeline MEM stage and the data memory.
// Latency: accept at edge T, mem_req from T+1, response the cycle after mem_ack (faults respond at T+1).
// Backpressure: req_ready is high only in IDLE; responses cannot be stalled and pulse for one cycle.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   req_valid/req_ready    pipeline request handshake
//   req_we, req_type       store flag, access type (word/half/byte/halfu/byteu/left/right)
//   req_addr               byte address
//   req_wdata, req_rt_old  store data and current rt (merge source for lwl/lwr)
//   resp_valid/rdata/exc   one-cycle response with load result and exception code
//   mem_*                  word-addressed memory request, held until mem_ack or timeout
module lsu_initiator #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] ADDR_HI = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [2:0] T_WORD  = 3'd0;
  localparam logic [2:0] T_HALF  = 3'd1;
  localparam logic [2:0] T_BYTE  = 3'd2;
  localparam logic [2:0] T_HALFU = 3'd3;
  localparam logic [2:0] T_BYTEU = 3'd4;
  localparam logic [2:0] T_LEFT  = 3'd5;
  localparam logic [2:0] T_RIGHT = 3'd6;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_LOAD    = 2'd1;
  localparam logic [1:0] EXC_STORE   = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;

  localparam logic [16:0] TIMEOUT_LIM = TIMEOUT[16:0];

  state_t      state;
  logic [2:0]  typ_q;
  logic [1:0]  k_q;
  logic [31:0] rt_old_q;
  logic [15:0] tmo_cnt;
  logic [16:0] tmo_next;

  logic [1:0]  acc_k;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        acc_misalign;
  logic        acc_fault;

  logic [31:0] rd_shr;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  // Gated by reset so the block never advertises readiness while held in reset.
  assign req_ready = (state == S_IDLE) && reset;

  assign tmo_next = {1'b0, tmo_cnt} + 17'd1;

  // Request decode: lane enables, lane-shifted store data and alignment check.
  always_comb begin
    acc_k        = req_addr[1:0];
    acc_be       = 4'b1111;
    acc_wdata    = req_wdata;
    acc_misalign = 1'b0;
    case (req_type)
      T_HALF, T_HALFU: begin
        acc_be       = 4'b0011 << {req_addr[1], 1'b0};
        acc_wdata    = {req_wdata[15:0], req_wdata[15:0]};
        acc_misalign = req_addr[0];
      end
      T_BYTE, T_BYTEU: begin
        acc_be    = 4'b0001 << acc_k;
        acc_wdata = {4{req_wdata[7:0]}};
      end
      T_LEFT: begin
        // ~k == 3-k for a 2-bit offset: lanes k..0 carry the top bytes of rt.
        acc_be    = 4'b1111 >> (~acc_k);
        acc_wdata = req_wdata >> {~acc_k, 3'b000};
      end
      T_RIGHT: begin
        acc_be    = 4'b1111 << acc_k;
        acc_wdata = req_wdata << {acc_k, 3'b000};
      end
      default: begin
        // word and the reserved encoding
        acc_be       = 4'b1111;
        acc_wdata    = req_wdata;
        acc_misalign = |acc_k;
      end
    endcase
    acc_fault = acc_misalign || (req_addr > ADDR_HI);
  end

  // Load extraction from the acknowledged word, using the registered access.
  always_comb begin
    rd_shr  = mem_rdata >> {k_q, 3'b000};
    rd_half = k_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    case (typ_q)
      T_HALF:  ld_data = {{16{rd_half[15]}}, rd_half};
      T_HALFU: ld_data = {16'h0000, rd_half};
      T_BYTE:  ld_data = {{24{rd_shr[7]}}, rd_shr[7:0]};
      T_BYTEU: ld_data = {24'h000000, rd_shr[7:0]};
      T_LEFT: begin
        // Memory bytes land in the top of rt; the low 8*(3-k) bits keep rt_old.
        ld_data = (mem_rdata << {~k_q, 3'b000})
                | (rt_old_q & ~(32'hFFFF_FFFF << {~k_q, 3'b000}));
      end
      T_RIGHT: begin
        // Memory bytes land in the bottom of rt; the top 8*k bits keep rt_old.
        ld_data = rd_shr | (rt_old_q & ~(32'hFFFF_FFFF >> {k_q, 3'b000}));
      end
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      typ_q      <= T_WORD;
      k_q        <= 2'd0;
      rt_old_q   <= 32'd0;
      tmo_cnt    <= 16'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_exc   <= EXC_NONE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            typ_q    <= req_type;
            k_q      <= acc_k;
            rt_old_q <= req_rt_old;
            tmo_cnt  <= 16'd0;
            if (acc_fault) begin
              // Faults answer straight away; the memory side is left untouched.
              resp_valid <= 1'b1;
              resp_rdata <= 32'd0;
              resp_exc   <= req_we ? EXC_STORE : EXC_LOAD;
              state      <= S_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= acc_be;
              mem_wdata <= acc_wdata;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // An ack in the cycle the counter expires still completes normally.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mem_we ? 32'd0 : ld_data;
            resp_exc   <= EXC_NONE;
            state      <= S_RESP;
          end else if (tmo_next == TIMEOUT_LIM) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 32'd0;
            resp_exc   <= EXC_TIMEOUT;
            state      <= S_RESP;
          end else begin
            tmo_cnt <= tmo_next[15:0];
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          resp_valid <= 1'b0;
          mem_req    <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
